batch_requester: RTL and testbench

- Initiator side of the start/valor/resultado/done handshake used by the team's compute units.
- Issues a batch of consecutive operand values to one compute unit and waits for each done.
- Captures each result into an internal FIFO that downstream logic reads.
- Sits between a control block (go/first_val/count) and a single compute unit.

---
 rtl/batch_requester_pkg.sv | 25 ++
 rtl/batch_requester_result_fifo.sv | 57 +++++
 rtl/batch_requester.sv | 154 +++++++++++++++
 tb/tb_batch_requester.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batch_requester_pkg.sv
// Shared constants for the batch requester and the compute-unit handshake.
// FSM state encoding, default widths and start/done levels.
package batch_requester_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int COUNT_W    = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    WAIT    = ST_WAIT,
    RELEASE = ST_RELEASE,
    FINISH  = ST_FINISH
  } state_e;

  localparam logic HS_ASSERT   = 1'b1;
  localparam logic HS_DEASSERT = 1'b0;

endpackage

// File: rtl/batch_requester_result_fifo.sv
// Result FIFO for the batch requester; write while full is accepted
// only together with a pop, reads from empty are ignored.
module result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_wr;
  logic              do_rd;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == PW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_wr);
    rd_ptr_d = rd_ptr_q + PW'(do_rd);
    cnt_d    = cnt_q + PW'(do_wr) - PW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/batch_requester.sv
// Issues a batch of consecutive operands to one compute unit and queues
// the results. BATCH_REQUESTER_TIMEOUT_EN adds a done watchdog.
module batch_requester
  import batch_requester_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               go,
  input  logic [DATA_W-1:0]  first_val,
  input  logic [COUNT_W-1:0] count,
  output logic               req_start,
  output logic [DATA_W-1:0]  req_valor,
  input  logic [DATA_W-1:0]  req_resultado,
  input  logic               req_done,
  input  logic               rd_en,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               batch_done,
  output logic               timeout_err
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0]  valor_q, valor_d;
  logic               start_q, start_d;
  logic               fifo_wr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               slot_free;
  logic               timed_out;

  // A pop on the same edge frees the slot we are about to claim
  assign slot_free = !fifo_full || rd_en;

`ifdef BATCH_REQUESTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            terr_q, terr_d;

  assign timed_out = (state_q == WAIT) && !req_done &&
                     (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_d   = wd_q;
    terr_d = terr_q | timed_out;
    if (state_q != WAIT) begin
      wd_d = '0;
    end else if (!timed_out) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    valor_d = valor_q;
    start_d = start_q;
    fifo_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          valor_d = first_val;
          rem_d   = count;
          if (count == '0) state_d = FINISH;
          else             state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (slot_free) begin
          start_d = HS_ASSERT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (req_done) begin
          fifo_wr = 1'b1;
          start_d = HS_DEASSERT;
          rem_d   = rem_q - COUNT_W'(1);
          valor_d = valor_q + DATA_W'(1);
          state_d = RELEASE;
        end else if (timed_out) begin
          start_d = HS_DEASSERT;
          state_d = FINISH;
        end
      end
      // Level-style done must fall before the next request goes out
      RELEASE: begin
        if (!req_done) begin
          if (rem_q != '0) state_d = ISSUE;
          else             state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= IDLE;
      rem_q   <= '0;
      valor_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      valor_q <= valor_d;
      start_q <= start_d;
    end
  end

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk0),
    .rst     (rst0),
    .wr_en   (fifo_wr),
    .wr_data (req_resultado),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign req_start  = start_q;
  assign req_valor  = valor_q;
  assign rd_valid   = !fifo_empty;
  assign busy       = (state_q != IDLE);
  assign batch_done = (state_q == FINISH);

endmodule

// File: tb/tb_batch_requester.sv
// Randomized scoreboard bench for batch_requester with a behavioural
// compute-unit responder (result = operand * 2).
module tb_batch_requester;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          go = 1'b0;
  logic [DW-1:0] first_val = '0;
  logic [3:0]    count = '0;
  logic          req_start;
  logic [DW-1:0] req_valor;
  logic [DW-1:0] req_resultado = '0;
  logic          req_done = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          batch_done;
  logic          timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] iss_q[$];
  logic [DW-1:0] exp_q[$];

  int resp_delay = 4;
  int resp_hold  = 1;
  bit resp_never = 1'b0;
  int n_resp     = 0;
  int rd_mode    = 0;
  int rd_pulses  = 0;
  int bd_count   = 0;
  bit bd_prev    = 1'b0;

  always #5 clk0 = ~clk0;

  batch_requester #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TMO)
  ) dut (
    .clk0          (clk0),
    .rst0          (rst0),
    .go            (go),
    .first_val     (first_val),
    .count         (count),
    .req_start     (req_start),
    .req_valor     (req_valor),
    .req_resultado (req_resultado),
    .req_done      (req_done),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .busy          (busy),
    .batch_done    (batch_done),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compute-unit model: answers each start after a delay, holding done
  initial begin : responder
    int phase;
    int cnt;
    logic [DW-1:0] v;
    phase = 0;
    cnt = 0;
    v = '0;
    forever begin
      @(negedge clk0);
      if (rst0) begin
        req_done = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (req_start && !resp_never) begin
            if (iss_q.size() == 0) check("unexpected_issue", 1, 0);
            else check("req_valor", req_valor, iss_q.pop_front());
            v = req_valor;
            cnt = (resp_delay < 0) ? int'($urandom_range(1, 6)) : resp_delay;
            phase = 1;
          end
          1: begin
            check("start_held", req_start, 1);
            check("valor_stable", req_valor, v);
            if (cnt <= 1) begin
              req_done = 1'b1;
              req_resultado = DW'(v * 2);
              n_resp++;
              cnt = (resp_hold < 0) ? int'($urandom_range(1, 5)) : resp_hold;
              phase = 2;
            end else cnt--;
          end
          default: begin
            check("start_low_while_done", req_start, 0);
            if (cnt <= 1) begin
              req_done = 1'b0;
              phase = 0;
            end else cnt--;
          end
        endcase
      end
    end
  end

  // Reader / scoreboard monitor
  initial begin : reader
    forever begin
      @(negedge clk0);
      if (rd_mode == 1) rd_en = 1'($urandom_range(0, 1));
      else if (rd_pulses > 0) begin
        rd_en = 1'b1;
        rd_pulses--;
      end else rd_en = 1'b0;
      if (!rst0) begin
        if (rd_valid && exp_q.size() == 0)
          check("rd_valid_unexpected", 1, 0);
        else if (rd_en && rd_valid)
          check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk0) begin
    if (batch_done) begin
      bd_count++;
      if (bd_prev) check("batch_done_one_cycle", 1, 0);
    end
    bd_prev = batch_done;
  end

  task automatic start_batch(input logic [DW-1:0] f, input logic [3:0] c);
    bit was_empty;
    was_empty = !rd_valid;
    for (int i = 0; i < int'(c); i++) begin
      iss_q.push_back(DW'(int'(f) + i));
      exp_q.push_back(DW'(2 * (int'(f) + i)));
    end
    go = 1'b1;
    first_val = f;
    count = c;
    @(negedge clk0);
    go = 1'b0;
    first_val = DW'($urandom);
    count = 4'($urandom);
    check("busy_after_go", busy, 1);
    if (c == 0) begin
      check("noop_batch_done", batch_done, 1);
      check("noop_no_start", req_start, 0);
    end else if (was_empty) begin
      @(negedge clk0);
      check("start_latency", req_start, 1);
    end
  endtask

  task automatic wait_batch(input int target);
    int n;
    n = 0;
    while (bd_count < target && n < 3000) begin
      @(negedge clk0);
      n++;
    end
    check("batch_done_seen", 32'(bd_count >= target), 1);
    @(negedge clk0);
    check("busy_low_after", busy, 0);
    check("batch_done_count", bd_count, target);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_mode = 1;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk0);
      n++;
    end
    rd_mode = 0;
    @(negedge clk0);
    @(negedge clk0);
    check("drained", exp_q.size(), 0);
    check("fifo_empty_after_drain", rd_valid, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int tgt;
    int r0;
    int n;
    repeat (3) @(negedge clk0);
    check("rst_req_start", req_start, 0);
    check("rst_req_valor", req_valor, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst0 = 1'b0;
    @(negedge clk0);

    // Basic batch with a fixed four-cycle responder
    resp_delay = 4;
    resp_hold = 1;
    r0 = n_resp;
    tgt = bd_count + 1;
    start_batch(8'd3, 4'd3);
    wait_batch(tgt);
    check("basic_issued", n_resp - r0, 3);
    check("basic_iss_q_empty", iss_q.size(), 0);
    drain();

    // Operand wraps modulo 2^DW
    tgt = bd_count + 1;
    start_batch(8'd254, 4'd3);
    wait_batch(tgt);
    check("wrap_iss_q_empty", iss_q.size(), 0);
    drain();

    // count==0 is a no-op
    r0 = n_resp;
    tgt = bd_count + 1;
    start_batch(8'd77, 4'd0);
    wait_batch(tgt);
    check("noop_no_response", n_resp - r0, 0);

    // Backpressure: FIFO fills, FSM parks in ISSUE
    resp_delay = -1;
    rd_mode = 0;
    r0 = n_resp;
    tgt = bd_count + 1;
    start_batch(8'd20, 4'd10);
    n = 0;
    while (n_resp - r0 < DEPTH && n < 500) begin
      @(negedge clk0);
      n++;
    end
    repeat (20) @(negedge clk0);
    check("bp_stored", n_resp - r0, DEPTH);
    check("bp_start_low", req_start, 0);
    check("bp_busy", busy, 1);
    check("bp_rd_valid", rd_valid, 1);
    rd_pulses = 2;
    wait_batch(tgt);
    check("bp_all_done", n_resp - r0, 10);
    drain();

    // Level-style done held for five cycles
    resp_delay = 2;
    resp_hold = 5;
    r0 = n_resp;
    tgt = bd_count + 1;
    start_batch(8'd100, 4'd3);
    wait_batch(tgt);
    check("level_issued", n_resp - r0, 3);
    drain();

    // Randomized batches with random reads
    resp_delay = -1;
    resp_hold = -1;
    rd_mode = 1;
    for (int k = 0; k < 10; k++) begin
      tgt = bd_count + 1;
      start_batch(DW'($urandom), 4'($urandom_range(0, 15)));
      wait_batch(tgt);
    end
    drain();
    check("rand_iss_q_empty", iss_q.size(), 0);

    // Reset in the middle of WAIT
    resp_delay = 8;
    resp_hold = 1;
    rd_mode = 0;
    r0 = n_resp;
    start_batch(8'd50, 4'd5);
    n = 0;
    while (!(n_resp - r0 >= 2 && req_start && !req_done) && n < 500) begin
      @(negedge clk0);
      n++;
    end
    check("pre_reset_fifo", rd_valid, 1);
    rst0 = 1'b1;
    go = 1'b1;
    first_val = 8'd9;
    count = 4'd4;
    @(negedge clk0);
    iss_q.delete();
    exp_q.delete();
    check("mid_rst_start", req_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_valor", req_valor, 0);
    repeat (3) begin
      @(negedge clk0);
      check("rst_go_ignored", busy, 0);
    end
    rst0 = 1'b0;
    go = 1'b0;
    @(negedge clk0);
    check("post_rst_busy", busy, 0);
    check("post_rst_start", req_start, 0);

    tgt = bd_count + 1;
    start_batch(8'd7, 4'd2);
    wait_batch(tgt);
    drain();

`ifdef BATCH_REQUESTER_TIMEOUT_EN
    resp_never = 1'b1;
    tgt = bd_count + 1;
    start_batch(8'd10, 4'd3);
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge clk0);
      n++;
    end
    check("timeout_wait_cycles", n, TMO);
    check("timeout_start_low", req_start, 0);
    wait_batch(tgt);
    check("timeout_fifo_empty", rd_valid, 0);
    iss_q.delete();
    exp_q.delete();
    resp_never = 1'b0;
    tgt = bd_count + 1;
    start_batch(8'd40, 4'd1);
    wait_batch(tgt);
    check("timeout_sticky", timeout_err, 1);
    drain();
`else
    check("timeout_err_tied_low", timeout_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
